// File: rtl/ysyx_24100005_sram_resp.sv
// Clocked data-memory responder: one word read or byte-masked write per request
// handshake, serviced from an internal array after LATENCY cycles and returned on
// a separate valid/ready response channel with an out-of-range error flag.
module ysyx_24100005_sram_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The counter only ever holds LATENCY-2 down to 0.
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;

  logic          lat_wen;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_wmask;

  logic [31:0]   mem [DEPTH];

  logic          req_fire;
  logic          enter_resp;
  logic          acc_wen;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wmask;
  logic [31:0]   acc_off;
  logic [31:0]   acc_word;
  logic          acc_in_range;
  logic [AW-1:0] acc_idx;

  assign req_fire = req_valid && req_ready;

  // State register; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs derived from the current state.
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP) && !rst;
  end

  // Access operands: with LATENCY==1 the array is touched on the accept edge
  // itself, before the request has been latched, so take the live bus in IDLE.
  always_comb begin
    if (state == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_wen   = lat_wen;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wmask = lat_wmask;
    end
    acc_off      = acc_addr - BASE;
    acc_word     = acc_off >> 2;
    acc_in_range = (acc_addr >= BASE) && (acc_word < DEPTH);
    acc_idx      = acc_word[AW-1:0];
    enter_resp   = (state_next == RESP) && (state != RESP);
  end

  // Request latch, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            lat_wen   <= req_wen;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            cnt       <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
      if (enter_resp) begin
        if (!acc_in_range) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          rsp_err   <= 1'b0;
          rsp_rdata <= acc_wen ? '0 : mem[acc_idx];
        end
      end
    end
  end

  // Byte-masked array write committed on the edge entering RESP; never under reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_wen && acc_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_sram_resp.sv
// Bench for ysyx_24100005_sram_resp: three instances (LATENCY 1, 2, 5) driven one
// transaction at a time; expected responses go into a scoreboard queue at issue
// and a negedge monitor compares them whenever a response is presented.
module tb_ysyx_24100005_sram_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WIN = 16;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    longint      t;
  } exp_t;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_wen;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wmask [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  bit          rnd = 0;
  bit   [2:0]  prev_v = '0;
  bit   [2:0]  hs_prev = '0;
  exp_t        sbq [$];
  logic [31:0] ref_mem [3][WIN];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_24100005_sram_resp #(
      .DEPTH  (1024),
      .BASE   (BASE),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 5))
    ) dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_wen  (req_wen[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the map covers bytes [BASE, BASE + 4*1024); judged in 64-bit space.
  function automatic bit in_map(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= 64'h8000_0000) && (ua < 64'h8000_0000 + 4 * 1024);
  endfunction

  function automatic exp_t model(input int k, input bit wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask);
    exp_t e;
    int   idx;
    e.k = k; e.t = 0; e.rdata = '0; e.err = 1'b0;
    if (!in_map(addr)) begin
      e.err = 1'b1;
    end else begin
      idx = int'((addr - BASE) / 4);
      if (idx < WIN) begin
        if (wen) begin
          for (int b = 0; b < 4; b++)
            if (wmask[b]) ref_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          e.rdata = ref_mem[k][idx];
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = 32'h7FFF_FFFC;
      1: a = 32'h8000_1000 + ($urandom_range(0, 3) << 2);
      2: a = $urandom_range(0, 32'h7FFF_0000);
      default: a = BASE + ($urandom_range(0, WIN - 1) << 2) + $urandom_range(0, 3);
    endcase
    return a;
  endfunction

  // Issue one request on instance k and wait for its response to be consumed.
  task automatic xact(input int k, input bit wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask, input int stall);
    exp_t e;
    int   n;
    int   held;
    bit   ok;
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_wen[k] = wen; req_addr[k] = addr;
    req_wdata[k] = wdata; req_wmask[k] = wmask; rsp_ready[k] = 1'b0;
    n = 0; ok = 1'b0;
    while (n < 50 && !ok) begin
      @(negedge clk);
      if (req_ready[k]) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: inst %0d never raised req_ready", k);
      req_valid[k] = 1'b0;
      return;
    end
    e = model(k, wen, addr, wdata, wmask);
    e.t = cyc;
    sbq.push_back(e);
    @(posedge clk); #1;
    // Scramble the request bus: the responder must work from what it latched.
    req_valid[k] = 1'b0; req_wen[k] = 1'($urandom); req_addr[k] = $urandom;
    req_wdata[k] = $urandom; req_wmask[k] = 4'($urandom);
    n = 0; held = 0;
    while (n < 100 && (sbq.size() != 0 || rsp_valid[k])) begin
      if (rsp_valid[k]) begin
        if (held < stall) begin
          rsp_ready[k] = 1'b0;
          held++;
        end else begin
          rsp_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: inst %0d response pending=%0d", k, sbq.size());
      sbq.delete();
    end
    rsp_ready[k] = 1'b0;
  endtask

  // Scoreboard monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        prev_v[k]  = 1'b0;
        hs_prev[k] = 1'b0;
      end else begin
        if (hs_prev[k])
          chk("post_handshake", {rsp_valid[k], req_ready[k], rsp_err[k], rsp_rdata[k]},
              {1'b0, 1'b1, 1'b0, 32'h0});
        hs_prev[k] = 1'b0;
        if (rsp_valid[k]) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_rsp: inst %0d rsp_valid=1, required no response", k);
          end else begin
            e = sbq[0];
            chk("rsp_err_rdata", {rsp_err[k], rsp_rdata[k]}, {e.err, e.rdata});
            chk("req_ready_busy", req_ready[k], 1'b0);
            // Handshake seen in the cycle after edge T: rsp_valid after edge T+LATENCY.
            if (!prev_v[k]) chk("latency", cyc - e.t, lat_of(k));
            if (rsp_ready[k]) begin
              void'(sbq.pop_front());
              hs_prev[k] = 1'b1;
            end
          end
        end
        prev_v[k] = rsp_valid[k];
      end
    end
  end

  initial begin
    rst = '1; req_valid = '0; req_wen = '0; rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0; req_wmask[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_state", {req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]}, '0);
    @(posedge clk); #1;
    rst = '0;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < WIN; i++)
        xact(k, 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 0);

    // Full write then read back, on every latency.
    for (int k = 0; k < 3; k++) begin
      xact(k, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
      xact(k, 1'b0, 32'h8000_0010, '0, 4'h0, 0);
    end

    // Partial mask merge and empty mask.
    xact(1, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0);
    xact(1, 1'b0, 32'h8000_0010, '0, 4'h0, 0);
    xact(1, 1'b1, 32'h8000_0010, 32'h5555_AAAA, 4'b0000, 0);
    xact(1, 1'b0, 32'h8000_0013, '0, 4'hF, 0);

    // Out-of-range accesses, then confirm the array edge words are intact.
    xact(1, 1'b0, 32'h7FFF_FFFC, '0, 4'h0, 0);
    xact(1, 1'b0, 32'h8000_1000, '0, 4'h0, 0);
    xact(1, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0);
    xact(1, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0);
    xact(1, 1'b0, 32'h8000_0000, '0, 4'h0, 0);
    xact(1, 1'b0, 32'h8000_003C, '0, 4'h0, 0);

    // Backpressure: response held for 5 cycles.
    xact(1, 1'b0, 32'h8000_0010, '0, 4'h0, 5);
    xact(2, 1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 5);

    // Reset during WAIT of a write: it must never be committed.
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
    req_wdata[1] = ~ref_mem[1][8]; req_wmask[1] = 4'hF;
    @(negedge clk);
    chk("rst_test_accept", req_ready[1], 1'b1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("rst_hold", {req_ready[1], rsp_valid[1]}, 2'b00);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_idle", {rsp_valid[1], req_ready[1], rsp_err[1], rsp_rdata[1]},
          {1'b0, 1'b1, 1'b0, 32'h0});
    end
    xact(1, 1'b0, 32'h8000_0020, '0, 4'h0, 0);

    // Random stream with random response backpressure.
    rnd = 1'b1;
    repeat (180) begin
      int k;
      k = $urandom_range(0, 2);
      xact(k, 1'($urandom), rnd_addr(), $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_rsp: %0d responses never presented", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
